// File: rtl/program_loader.sv
// program_loader
// Receives a program image as a byte stream and writes it, one 32-bit word
// at a time, into an external program memory. The processor is held in reset
// for the whole session.
//
// Stream format: N low byte, N high byte, then 4*N data bytes (little-endian
// words), then one checksum byte. The checksum is the XOR of the data bytes.
//
// Ports
//   clk       : single clock, rising edge
//   rst       : asynchronous active-low reset
//   start     : one-cycle request to begin a session (IDLE/DONE/ERR only)
//   in_data   : stream byte
//   in_valid  : in_data is valid
//   in_ready  : loader accepts a byte this cycle
//   wr_en     : program memory write strobe (one cycle per word)
//   wr_addr   : program memory word address
//   wr_data   : instruction word
//   cpu_hold  : processor held in reset while a session runs
//   busy      : session in progress
//   done      : last session completed with a good checksum (sticky)
//   err       : last session failed (sticky)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start after reset
// LEN_LO | waiting for the low byte of the word count
// LEN_HI | waiting for the high byte; range check on the full count
// DATA   | collecting the four bytes of the next word
// WRITE  | one-cycle write strobe for the assembled word
// CHK    | waiting for the checksum byte
// DONE   | session ended with a matching checksum
// ERR    | session ended with a bad length or checksum
module program_loader #(
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] DEPTH_W = 17'(MEM_DEPTH);

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    // One bit wider than the address so it can reach MEM_DEPTH itself.
    logic [ADDR_W:0]   word_idx_q, word_idx_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        chk_q, chk_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              in_ready_q, in_ready_d;
    logic              wr_en_q, wr_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic [15:0]       len_full;
    logic [16:0]       idx_next;

    // in_ready_q always reflects the current state, so it gates acceptance.
    assign accept   = in_valid & in_ready_q;
    assign len_full = {in_data, len_q[7:0]};
    assign idx_next = 17'(word_idx_q) + 17'd1;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        chk_d      = chk_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN_LO;
                    len_d      = '0;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                    word_d     = '0;
                    chk_d      = '0;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = in_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = in_data;
                    if ({1'b0, len_full} > DEPTH_W) begin
                        state_d = S_ERR;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
                    chk_d      = chk_q ^ in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Address/data are loaded here so they are valid
                        // on the same cycle the strobe rises.
                        state_d   = S_WRITE;
                        wr_addr_d = word_idx_q[ADDR_W-1:0];
                        wr_data_d = {in_data, word_q[23:0]};
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_q + {{ADDR_W{1'b0}}, 1'b1};
                if (idx_next < {1'b0, len_q}) begin
                    state_d = S_DATA;
                end else begin
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (accept) begin
                    state_d = (in_data == chk_q) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered and decoded from the next state so they
        // line up exactly with state_q.
        in_ready_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                     (state_d == S_DATA)   || (state_d == S_CHK);
        busy_d     = in_ready_d || (state_d == S_WRITE);
        wr_en_d    = (state_d == S_WRITE);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            chk_q      <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            chk_q      <= chk_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign cpu_hold = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: directed scenarios plus randomized sessions,
// checked against a stream-level model (expected writes, checksum, outcome).
module tb_program_loader;

    localparam int MEM_DEPTH = 1024;
    localparam int ADDR_W    = 10;

    logic              clk;
    logic              rst;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0]         words[$];
    logic [ADDR_W+31:0]  wq[$];

    program_loader #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en === 1'b1) wq.push_back({wr_addr, wr_data});
    end

    function automatic logic [7:0] model_xor(input int n);
        logic [7:0] x = 8'h00;
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = words[i];
            x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
        end
        return x;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL in_ready_timeout: in_ready=%b, required 1 within 20 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic int pick_gap(input int mode);
        if (mode == 1) return 1;
        if (mode == 2) return int'($urandom_range(0, 2));
        return 0;
    endfunction

    // Runs one complete session from start pulse to end state and checks the
    // outcome, the writes and the idle outputs against the stream model.
    task automatic run_session(input string tag, input logic [15:0] nlen,
                               input bit good, input int gmode, input bit mid_start);
        bit         over;
        logic [7:0] x, chk;
        logic [31:0] w;
        int         n;
        bit         exp_done;
        int         exp_writes;

        over       = (int'(nlen) > MEM_DEPTH);
        x          = over ? 8'h00 : model_xor(int'(nlen));
        chk        = good ? x : (x ^ 8'(1 + $urandom_range(0, 254)));
        exp_done   = !over && good;
        exp_writes = over ? 0 : int'(nlen);
        wq.delete();

        pulse_start();
        send_byte(nlen[7:0], pick_gap(gmode));
        send_byte(nlen[15:8], pick_gap(gmode));
        if (!over) begin
            for (int i = 0; i < int'(nlen); i++) begin
                w = words[i];
                for (int b = 0; b < 4; b++) begin
                    if (mid_start && i == 0 && b == 1) start = 1'b1;
                    send_byte(w[8*b +: 8], pick_gap(gmode));
                    start = 1'b0;
                end
            end
            send_byte(chk, pick_gap(gmode));
        end

        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);

        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy: got %b, required 0", tag, busy);
        end
        vectors++;
        if (done !== exp_done) begin
            miscompares++;
            $display("FAIL %s done: got %b, required %b", tag, done, exp_done);
        end
        vectors++;
        if (err !== !exp_done) begin
            miscompares++;
            $display("FAIL %s err: got %b, required %b", tag, err, !exp_done);
        end
        vectors++;
        if (cpu_hold !== 1'b0 || in_ready !== 1'b0 || wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle_outputs: cpu_hold=%b in_ready=%b wr_en=%b, required 0 0 0",
                     tag, cpu_hold, in_ready, wr_en);
        end
        vectors++;
        if (wq.size() != exp_writes) begin
            miscompares++;
            $display("FAIL %s write_count: got %0d, required %0d", tag, wq.size(), exp_writes);
        end
        for (int i = 0; i < wq.size() && i < exp_writes; i++) begin
            vectors++;
            if (wq[i] !== {ADDR_W'(i), words[i]}) begin
                miscompares++;
                $display("FAIL %s write[%0d]: got addr=%0d data=%08h, required addr=%0d data=%08h",
                         tag, i, wq[i][ADDR_W+31:32], wq[i][31:0], i, words[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        vectors++;
        if ({in_ready, wr_en, cpu_hold, busy, done, err} !== 6'b0 ||
            wr_addr !== '0 || wr_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: flags=%b addr=%0h data=%08h, required all 0",
                     {in_ready, wr_en, cpu_hold, busy, done, err}, wr_addr, wr_data);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        words = '{32'h00100093};
        run_session("single_word", 16'd1, 1'b1, 0, 1'b0);
    endtask

    task automatic test_two_words_gapped();
        words = '{32'h00100093, 32'h00200113};
        run_session("two_words_gapped", 16'd2, 1'b1, 1, 1'b0);
    endtask

    task automatic test_bad_checksum();
        words = '{32'hDEADBEEF};
        run_session("bad_checksum", 16'd1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_too_long();
        words.delete();
        run_session("too_long", 16'h0401, 1'b1, 0, 1'b0);
    endtask

    task automatic test_zero_len();
        words.delete();
        run_session("zero_len", 16'd0, 1'b1, 0, 1'b0);
    endtask

    task automatic test_start_ignored();
        words = '{32'h12345678, 32'h9ABCDEF0};
        run_session("start_ignored", 16'd2, 1'b1, 0, 1'b1);
    endtask

    task automatic test_full_depth();
        words.delete();
        for (int i = 0; i < MEM_DEPTH; i++) words.push_back($urandom);
        run_session("full_depth", 16'(MEM_DEPTH), 1'b1, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        wq.delete();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if ({in_ready, wr_en, cpu_hold, busy, done, err} !== 6'b0 ||
            wr_addr !== '0 || wr_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: flags=%b addr=%0h data=%08h, required all 0",
                     {in_ready, wr_en, cpu_hold, busy, done, err}, wr_addr, wr_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (wq.size() != 0) begin
            miscompares++;
            $display("FAIL reset_mid_no_write: got %0d writes, required 0", wq.size());
        end
        words = '{32'h00100093};
        run_session("after_reset", 16'd1, 1'b1, 0, 1'b0);
    endtask

    task automatic test_random();
        int n;
        bit good;
        for (int s = 0; s < 15; s++) begin
            n    = int'($urandom_range(0, 6));
            good = ($urandom_range(0, 3) != 0);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom);
            run_session($sformatf("random_%0d", s), 16'(n), good, 2, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_two_words_gapped();
        test_bad_checksum();
        test_too_long();
        test_zero_len();
        test_start_ignored();
        test_reset_mid();
        test_full_depth();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
